reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  core clock.
REQ-002 SHALL have: rst  in  1  reset; one clock domain; reset is synchronous and active-high.
REQ-003 SHALL have: alloc_valid  in  DISP_WIDTH  per-lane allocate request; lanes contiguous, lane 1 valid only if lane 0 valid.
REQ-004 SHALL have: alloc_entry  in  DISP_WIDTH x ROB_Entry  entry payload from rename/dispatch.
REQ-005 SHALL have: alloc_ready  out  1  ROB can accept DISP_WIDTH entries this cycle.
REQ-006 SHALL have: alloc_index  out  DISP_WIDTH x log2(NUM_ROB_ENTS)  index assigned to each lane (tail, tail+1).
REQ-007 SHALL have: cmpl_valid  in  NUM_FUS  writeback completion strobe per FU.
REQ-008 SHALL have: cmpl_index  in  NUM_FUS x log2(NUM_ROB_ENTS)  completing entry.
REQ-009 SHALL have: cmpl_mispred, cmpl_exception  in  NUM_FUS each  status for completing entry.
REQ-010 SHALL have: retire_valid  out  RETIRE_WIDTH  registered, lanes contiguous from lane 0.
REQ-011 SHALL have: retire_entry  out  RETIRE_WIDTH x ROB_Entry  registered retired payloads, oldest in lane 0.
REQ-012 SHALL have: flush  out  1, flush_pc  out  32  registered one-cycle pipeline flush and redirect PC.
REQ-013 SHALL have: count  out  log2(NUM_ROB_ENTS)+1  occupied entries; empty  out  1.

Function
REQ-014 SHALL be a circular buffer of NUM_ROB_ENTS (64) entries, head/tail pointers wrapping modulo 64, per-entry valid and done bits.
REQ-015 alloc_ready SHALL equal (64 - count >= DISP_WIDTH) and not flush, computed from pre-edge state only.
REQ-016 On an edge with alloc_ready and alloc_valid[i], lane i SHALL write alloc_entry[i] at tail+i, set valid, clear done, take br_mispred/exception from the payload OR-ed with later completion; tail advances by accepted lanes.
REQ-017 On an edge with cmpl_valid[f] and entry cmpl_index[f] valid, SHALL set done and OR in cmpl_mispred/cmpl_exception; completions to invalid entries SHALL be ignored; multiple FUs to one index SHALL OR.
REQ-018 Retire selection SHALL use pre-edge state: retire the longest prefix of head..head+RETIRE_WIDTH-1 that is valid and done, max RETIRE_WIDTH.
REQ-019 An entry with br_mispred or exception SHALL retire and be the last lane retired that edge.
REQ-020 Retired entries SHALL appear on retire_valid/retire_entry the cycle after the retiring edge; head advances by retired count; retired entries invalidated.
REQ-021 Minimum latency: completion at edge N, retire at edge N+1, retire_valid high after edge N+1.
REQ-022 On retiring a mispred/exception entry, the same edge SHALL invalidate all entries, set head=tail=0, count=0, register flush=1 and flush_pc=entry pc for exactly one cycle.
REQ-023 Allocations and completions on a flushing edge SHALL be discarded.
REQ-024 Simultaneous alloc and retire SHALL update count = count + accepted - retired; full (64) and empty (0) both legal; empty = (count == 0).

Reset
REQ-025 rst SHALL clear head, tail, count, all valid/done bits, retire_valid, flush, flush_pc; alloc_ready=1, empty=1 in the cycle after reset.
REQ-026 rst mid-operation SHALL discard all entries with no retire or flush pulse emitted.

Structure
REQ-027 NUM_ROB_ENTS, RETIRE_WIDTH, DISP_WIDTH, NUM_FUS, ROB_Entry and a new rob_idx_t typedef SHALL live in CORE_PKG.
REQ-028 Retire-prefix selection SHALL be a combinational sub-module rob_retire_select (done vector in, retire count and stop-lane out).

Verification
REQ-029 Reset, alloc 2 entries (pc 0x100, 0x104), complete both -> next edge+1 retire_valid=0b0011, count returns 0.
REQ-030 Fill 64 entries -> alloc_ready=0 at count 63 and 64; retire 4 -> alloc_ready=1 again; indices wrap 63->0.
REQ-031 Complete index head+1 only -> no retire; then complete head -> both retire same cycle in order.
REQ-032 6 done entries, entry head+2 mispred, pc 0x200 -> retire_valid=0b0111, flush=1 one cycle, flush_pc=0x200, count=0.
REQ-033 Alloc and completion on flushing edge, and rst asserted with 10 live entries -> all discarded, empty=1, no retire pulses.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the reorder buffer slice.
// Holds the ROB geometry, the widths derived from it, the ROB index type and
// the ROB_Entry payload carried from rename/dispatch to retirement.
package core_pkg;

  localparam int NUM_ROB_ENTS = 64;
  localparam int RETIRE_WIDTH = 4;
  localparam int DISP_WIDTH   = 2;
  localparam int NUM_FUS      = 4;

  localparam int ROB_IDX_W  = $clog2(NUM_ROB_ENTS);
  localparam int COUNT_W    = ROB_IDX_W + 1;            // must hold 0..NUM_ROB_ENTS
  localparam int RET_CNT_W  = $clog2(RETIRE_WIDTH + 1);  // 0..RETIRE_WIDTH
  localparam int RET_LANE_W = $clog2(RETIRE_WIDTH);
  localparam int ACC_W      = $clog2(DISP_WIDTH + 1);    // 0..DISP_WIDTH

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  dest_reg;
    logic        br_mispred;
    logic        exception;
  } ROB_Entry;

endpackage

// File: rtl/rob_retire_select.sv
// Retire-prefix selector for the reorder buffer.
// Ports:
//   ready        in  RETIRE_WIDTH  entry at head+k is valid and done
//   stop         in  RETIRE_WIDTH  entry at head+k carries mispredict/exception
//   retire_count out RET_CNT_W     length of the retirable prefix
//   stop_hit     out 1             a stopping entry is inside the prefix
//   stop_lane    out RET_LANE_W    lane of that stopping entry (last retired lane)
// Purely combinational.
module rob_retire_select
  import core_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] ready,
  input  logic [RETIRE_WIDTH-1:0] stop,
  output logic [RET_CNT_W-1:0]    retire_count,
  output logic                    stop_hit,
  output logic [RET_LANE_W-1:0]   stop_lane
);

  logic blocked;

  always_comb begin
    retire_count = '0;
    stop_hit     = 1'b0;
    stop_lane    = '0;
    blocked      = 1'b0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (!blocked) begin
        if (ready[k]) begin
          retire_count = RET_CNT_W'(k + 1);
          // A mispredicted/excepting entry still retires but ends the group.
          if (stop[k]) begin
            stop_hit  = 1'b1;
            stop_lane = RET_LANE_W'(k);
            blocked   = 1'b1;
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: 64-entry circular buffer allocating up to DISP_WIDTH entries
// per cycle in order, accepting out-of-order completions from NUM_FUS units and
// retiring up to RETIRE_WIDTH entries per cycle in order.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alloc_valid/alloc_entry       per-lane allocate request and payload
//   alloc_ready/alloc_index       room for a full dispatch group / slot per lane
//   cmpl_valid/cmpl_index         per-FU completion strobe and target entry
//   cmpl_mispred/cmpl_exception   per-FU completion status
//   retire_valid/retire_entry     registered retired group, oldest in lane 0
//   flush/flush_pc                registered one-cycle flush and redirect PC
//   count/empty                   occupancy
module reorder_buffer
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DISP_WIDTH-1:0]   alloc_valid,
  input  ROB_Entry                alloc_entry [DISP_WIDTH],
  output logic                    alloc_ready,
  output rob_idx_t                alloc_index [DISP_WIDTH],
  input  logic [NUM_FUS-1:0]      cmpl_valid,
  input  rob_idx_t                cmpl_index [NUM_FUS],
  input  logic [NUM_FUS-1:0]      cmpl_mispred,
  input  logic [NUM_FUS-1:0]      cmpl_exception,
  output logic [RETIRE_WIDTH-1:0] retire_valid,
  output ROB_Entry                retire_entry [RETIRE_WIDTH],
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic [COUNT_W-1:0]      count,
  output logic                    empty
);

  // Pointer / occupancy state
  rob_idx_t                head_reg;
  rob_idx_t                tail_reg;
  logic [COUNT_W-1:0]      count_reg;
  logic [COUNT_W-1:0]      count_next;

  // Per-entry status; flags live outside the payload so completions can OR in.
  logic [NUM_ROB_ENTS-1:0] valid_reg, valid_next;
  logic [NUM_ROB_ENTS-1:0] done_reg,  done_next;
  logic [NUM_ROB_ENTS-1:0] mis_reg,   mis_next;
  logic [NUM_ROB_ENTS-1:0] exc_reg,   exc_next;
  ROB_Entry                entries [NUM_ROB_ENTS];

  // Registered outputs
  logic [RETIRE_WIDTH-1:0] retire_valid_reg;
  ROB_Entry                retire_entry_reg [RETIRE_WIDTH];
  logic                    flush_reg;
  logic [31:0]             flush_pc_reg;

  // Allocation
  logic [DISP_WIDTH-1:0]   alloc_fire;
  logic [ACC_W-1:0]        accepted;

  // Retire window
  rob_idx_t                retire_idx  [RETIRE_WIDTH];
  ROB_Entry                retire_view [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] ret_ready;
  logic [RETIRE_WIDTH-1:0] ret_stop;
  logic [RETIRE_WIDTH-1:0] retire_lane;
  logic [RET_CNT_W-1:0]    retire_count;
  logic                    stop_hit;
  logic [RET_LANE_W-1:0]   stop_lane;

  assign alloc_ready = ((COUNT_W'(NUM_ROB_ENTS) - count_reg) >= COUNT_W'(DISP_WIDTH)) && !flush_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DISP_WIDTH; gi++) begin : g_alloc
      assign alloc_index[gi] = tail_reg + rob_idx_t'(gi);
      assign alloc_fire[gi]  = alloc_ready & alloc_valid[gi];
    end

    for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_window
      assign retire_idx[gi]  = head_reg + rob_idx_t'(gi);
      assign ret_ready[gi]   = valid_reg[retire_idx[gi]] & done_reg[retire_idx[gi]];
      assign ret_stop[gi]    = mis_reg[retire_idx[gi]] | exc_reg[retire_idx[gi]];
      assign retire_lane[gi] = RET_CNT_W'(gi) < retire_count;
      // Present the payload with the flags accumulated from completions.
      always_comb begin
        retire_view[gi]            = entries[retire_idx[gi]];
        retire_view[gi].br_mispred = mis_reg[retire_idx[gi]];
        retire_view[gi].exception  = exc_reg[retire_idx[gi]];
      end
      assign retire_valid[gi] = retire_valid_reg[gi];
      assign retire_entry[gi] = retire_entry_reg[gi];
    end
  endgenerate

  rob_retire_select u_retire_select (
    .ready        (ret_ready),
    .stop         (ret_stop),
    .retire_count (retire_count),
    .stop_hit     (stop_hit),
    .stop_lane    (stop_lane)
  );

  always_comb begin
    accepted = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      accepted = accepted + ACC_W'(alloc_fire[i]);
    end
  end

  assign count_next = count_reg + COUNT_W'(accepted) - COUNT_W'(retire_count);

  // Next entry status. Order matters: completions, then retirement clears,
  // then allocation (an allocated slot is always invalid pre-edge).
  always_comb begin
    valid_next = valid_reg;
    done_next  = done_reg;
    mis_next   = mis_reg;
    exc_next   = exc_reg;
    for (int f = 0; f < NUM_FUS; f++) begin
      if (cmpl_valid[f] && valid_reg[cmpl_index[f]]) begin
        done_next[cmpl_index[f]] = 1'b1;
        mis_next[cmpl_index[f]]  = mis_next[cmpl_index[f]] | cmpl_mispred[f];
        exc_next[cmpl_index[f]]  = exc_next[cmpl_index[f]] | cmpl_exception[f];
      end
    end
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (retire_lane[k]) begin
        valid_next[retire_idx[k]] = 1'b0;
        done_next[retire_idx[k]]  = 1'b0;
      end
    end
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (alloc_fire[i]) begin
        valid_next[alloc_index[i]] = 1'b1;
        done_next[alloc_index[i]]  = 1'b0;
        mis_next[alloc_index[i]]   = alloc_entry[i].br_mispred;
        exc_next[alloc_index[i]]   = alloc_entry[i].exception;
      end
    end
    // A flushing retirement discards everything, including this edge's traffic.
    if (stop_hit) begin
      valid_next = '0;
      done_next  = '0;
      mis_next   = '0;
      exc_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      valid_reg        <= '0;
      done_reg         <= '0;
      mis_reg          <= '0;
      exc_reg          <= '0;
      retire_valid_reg <= '0;
      flush_reg        <= 1'b0;
      flush_pc_reg     <= '0;
    end else begin
      valid_reg        <= valid_next;
      done_reg         <= done_next;
      mis_reg          <= mis_next;
      exc_reg          <= exc_next;
      retire_valid_reg <= retire_lane;
      flush_reg        <= stop_hit;
      if (stop_hit) begin
        flush_pc_reg <= retire_view[stop_lane].pc;
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
      end else begin
        head_reg  <= head_reg + rob_idx_t'(retire_count);
        tail_reg  <= tail_reg + rob_idx_t'(accepted);
        count_reg <= count_next;
      end
    end
  end

  // Payload storage and retired payloads need no reset: qualified by valid bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (alloc_fire[i] && !stop_hit) begin
        entries[alloc_index[i]] <= alloc_entry[i];
      end
    end
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      retire_entry_reg[k] <= retire_view[k];
    end
  end

  assign flush    = flush_reg;
  assign flush_pc = flush_pc_reg;
  assign count    = count_reg;
  assign empty    = (count_reg == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer.
module tb_reorder_buffer;
  import core_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DISP_WIDTH-1:0]   alloc_valid;
  ROB_Entry                alloc_entry [DISP_WIDTH];
  logic                    alloc_ready;
  rob_idx_t                alloc_index [DISP_WIDTH];
  logic [NUM_FUS-1:0]      cmpl_valid;
  rob_idx_t                cmpl_index [NUM_FUS];
  logic [NUM_FUS-1:0]      cmpl_mispred;
  logic [NUM_FUS-1:0]      cmpl_exception;
  logic [RETIRE_WIDTH-1:0] retire_valid;
  ROB_Entry                retire_entry [RETIRE_WIDTH];
  logic                    flush;
  logic [31:0]             flush_pc;
  logic [COUNT_W-1:0]      count;
  logic                    empty;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_entry    (alloc_entry),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .cmpl_valid     (cmpl_valid),
    .cmpl_index     (cmpl_index),
    .cmpl_mispred   (cmpl_mispred),
    .cmpl_exception (cmpl_exception),
    .retire_valid   (retire_valid),
    .retire_entry   (retire_entry),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .count          (count),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid    = '0;
    cmpl_valid     = '0;
    cmpl_mispred   = '0;
    cmpl_exception = '0;
    for (int i = 0; i < DISP_WIDTH; i++) alloc_entry[i] = '0;
    for (int f = 0; f < NUM_FUS; f++) cmpl_index[f] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] pc, input logic mis, input logic exc);
    alloc_valid[lane]            = 1'b1;
    alloc_entry[lane].pc         = pc;
    alloc_entry[lane].dest_reg   = 6'(lane + 1);
    alloc_entry[lane].br_mispred = mis;
    alloc_entry[lane].exception  = exc;
  endtask

  task automatic set_cmpl(input int fu, input int idx, input logic mis, input logic exc);
    cmpl_valid[fu]     = 1'b1;
    cmpl_index[fu]     = rob_idx_t'(idx);
    cmpl_mispred[fu]   = mis;
    cmpl_exception[fu] = exc;
  endtask

  task automatic test_reset();
    $display("test_reset");
    do_reset();
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
    checks++; if (retire_valid !== 4'b0000) begin errors++; $display("FAIL reset_retire_valid: got %b expected 0000", retire_valid); end
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush: got %0b/%h expected 0/00000000", flush, flush_pc); end
    checks++; if (alloc_index[0] !== 6'd0 || alloc_index[1] !== 6'd1) begin errors++; $display("FAIL reset_alloc_index: got %0d,%0d expected 0,1", alloc_index[0], alloc_index[1]); end
  endtask

  task automatic test_basic_retire();
    $display("test_basic_retire");
    do_reset();
    set_lane(0, 32'h100, 1'b0, 1'b0);
    set_lane(1, 32'h104, 1'b0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (count !== 7'd2) begin errors++; $display("FAIL basic_count_after_alloc: got %0d expected 2", count); end
    checks++; if (alloc_index[0] !== 6'd2) begin errors++; $display("FAIL basic_tail: got %0d expected 2", alloc_index[0]); end
    set_cmpl(0, 0, 1'b0, 1'b0);
    set_cmpl(1, 1, 1'b0, 1'b0);
    tick();  // completion edge N
    clear_inputs();
    checks++; if (retire_valid !== 4'b0000) begin errors++; $display("FAIL basic_no_early_retire: got %b expected 0000", retire_valid); end
    tick();  // retire edge N+1
    checks++; if (retire_valid !== 4'b0011) begin errors++; $display("FAIL basic_retire_valid: got %b expected 0011", retire_valid); end
    checks++; if (retire_entry[0].pc !== 32'h100 || retire_entry[1].pc !== 32'h104) begin errors++; $display("FAIL basic_retire_pc: got %h,%h expected 00000100,00000104", retire_entry[0].pc, retire_entry[1].pc); end
    checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_count_after_retire: got %0d/%0b expected 0/1", count, empty); end
    tick();
    checks++; if (retire_valid !== 4'b0000) begin errors++; $display("FAIL basic_retire_one_cycle: got %b expected 0000", retire_valid); end
  endtask

  task automatic test_fill_wrap();
    $display("test_fill_wrap");
    do_reset();
    for (int t = 0; t < 31; t++) begin
      set_lane(0, 32'h1000 + 32'(8 * t), 1'b0, 1'b0);
      set_lane(1, 32'h1004 + 32'(8 * t), 1'b0, 1'b0);
      tick();
    end
    checks++; if (count !== 7'd62 || alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_62: got count %0d ready %0b expected 62/1", count, alloc_ready); end
    set_lane(0, 32'h10F8, 1'b0, 1'b0);
    set_lane(1, 32'h10FC, 1'b0, 1'b0);
    tick();
    checks++; if (count !== 7'd64 || alloc_ready !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL fill_64: got count %0d ready %0b empty %0b expected 64/0/0", count, alloc_ready, empty); end
    tick();  // request held while full must be ignored
    clear_inputs();
    checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_full_ignore: got %0d expected 64", count); end
    for (int f = 0; f < 4; f++) set_cmpl(f, f, 1'b0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (retire_valid !== 4'b1111 || retire_entry[3].pc !== 32'h100C) begin errors++; $display("FAIL fill_retire4: got %b pc %h expected 1111 pc 0000100c", retire_valid, retire_entry[3].pc); end
    checks++; if (count !== 7'd60 || alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_after_retire: got count %0d ready %0b expected 60/1", count, alloc_ready); end
    checks++; if (alloc_index[0] !== 6'd0 || alloc_index[1] !== 6'd1) begin errors++; $display("FAIL fill_wrap_index: got %0d,%0d expected 0,1", alloc_index[0], alloc_index[1]); end
    set_lane(0, 32'h2000, 1'b0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (count !== 7'd61 || alloc_index[0] !== 6'd1) begin errors++; $display("FAIL fill_61: got count %0d idx %0d expected 61/1", count, alloc_index[0]); end
    set_lane(0, 32'h2004, 1'b0, 1'b0);
    set_lane(1, 32'h2008, 1'b0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (count !== 7'd63 || alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_63: got count %0d ready %0b expected 63/0", count, alloc_ready); end
  endtask

  task automatic test_out_of_order();
    $display("test_out_of_order");
    do_reset();
    set_lane(0, 32'h300, 1'b0, 1'b0);
    set_lane(1, 32'h304, 1'b0, 1'b0);
    tick();
    clear_inputs();
    set_cmpl(2, 1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (retire_valid !== 4'b0000 || count !== 7'd2) begin errors++; $display("FAIL ooo_blocked: got %b count %0d expected 0000/2", retire_valid, count); end
    set_cmpl(3, 0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (retire_valid !== 4'b0011) begin errors++; $display("FAIL ooo_retire_valid: got %b expected 0011", retire_valid); end
    checks++; if (retire_entry[0].pc !== 32'h300 || retire_entry[1].pc !== 32'h304) begin errors++; $display("FAIL ooo_order: got %h,%h expected 00000300,00000304", retire_entry[0].pc, retire_entry[1].pc); end
  endtask

  task automatic test_mispred_flush();
    $display("test_mispred_flush");
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_lane(0, 32'h1F8 + 32'(8 * t), 1'b0, 1'b0);
      set_lane(1, 32'h1FC + 32'(8 * t), 1'b0, 1'b0);
      tick();
    end
    clear_inputs();
    set_cmpl(0, 4, 1'b0, 1'b0);
    set_cmpl(1, 5, 1'b0, 1'b0);
    tick();
    clear_inputs();
    set_cmpl(0, 0, 1'b0, 1'b0);
    set_cmpl(1, 1, 1'b0, 1'b0);
    set_cmpl(2, 2, 1'b1, 1'b0);
    set_cmpl(3, 3, 1'b0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (retire_valid !== 4'b0000 || count !== 7'd6) begin errors++; $display("FAIL mis_pre: got %b count %0d expected 0000/6", retire_valid, count); end
    tick();
    checks++; if (retire_valid !== 4'b0111) begin errors++; $display("FAIL mis_retire_valid: got %b expected 0111", retire_valid); end
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h200) begin errors++; $display("FAIL mis_flush: got %0b/%h expected 1/00000200", flush, flush_pc); end
    checks++; if (retire_entry[2].pc !== 32'h200 || retire_entry[2].br_mispred !== 1'b1) begin errors++; $display("FAIL mis_lane2: got pc %h mis %0b expected 00000200/1", retire_entry[2].pc, retire_entry[2].br_mispred); end
    checks++; if (count !== 7'd0 || empty !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL mis_state: got count %0d empty %0b ready %0b expected 0/1/0", count, empty, alloc_ready); end
    tick();
    checks++; if (flush !== 1'b0 || retire_valid !== 4'b0000) begin errors++; $display("FAIL mis_one_cycle: got flush %0b rv %b expected 0/0000", flush, retire_valid); end
    checks++; if (alloc_ready !== 1'b1 || alloc_index[0] !== 6'd0) begin errors++; $display("FAIL mis_after: got ready %0b idx %0d expected 1/0", alloc_ready, alloc_index[0]); end
  endtask

  task automatic test_discard();
    $display("test_discard");
    do_reset();
    set_lane(0, 32'h400, 1'b0, 1'b0);
    set_lane(1, 32'h404, 1'b0, 1'b0);
    tick();
    clear_inputs();
    set_cmpl(0, 0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    // Flushing edge: these allocations and the completion must vanish.
    set_lane(0, 32'h500, 1'b0, 1'b0);
    set_lane(1, 32'h504, 1'b0, 1'b0);
    set_cmpl(1, 1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h400 || retire_valid !== 4'b0001) begin errors++; $display("FAIL disc_flush: got %0b/%h rv %b expected 1/00000400/0001", flush, flush_pc, retire_valid); end
    checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL disc_count: got %0d/%0b expected 0/1", count, empty); end
    tick();
    tick();
    checks++; if (retire_valid !== 4'b0000 || count !== 7'd0 || alloc_index[0] !== 6'd0) begin errors++; $display("FAIL disc_residue: got rv %b count %0d idx %0d expected 0000/0/0", retire_valid, count, alloc_index[0]); end

    // Reset with 10 live entries, two of them about to retire.
    for (int t = 0; t < 5; t++) begin
      set_lane(0, 32'h600 + 32'(8 * t), 1'b0, 1'b0);
      set_lane(1, 32'h604 + 32'(8 * t), 1'b0, 1'b0);
      tick();
    end
    clear_inputs();
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL rst_live: got %0d expected 10", count); end
    set_cmpl(0, 0, 1'b0, 1'b0);
    set_cmpl(1, 1, 1'b1, 1'b0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_mid_count: got %0d/%0b expected 0/1", count, empty); end
    for (int t = 0; t < 4; t++) begin
      checks++; if (retire_valid !== 4'b0000 || flush !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: cycle %0d got rv %b flush %0b expected 0000/0", t, retire_valid, flush); end
      tick();
    end
    checks++; if (empty !== 1'b1 || alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_final: got empty %0b ready %0b expected 1/1", empty, alloc_ready); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_retire();
    test_fill_wrap();
    test_out_of_order();
    test_mispred_flush();
    test_discard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
